// File: rtl/me_pkg.sv
// Shared motion-estimation types: FSM state, default geometry, SAD width helper.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the SAD accumulator and its interface users.
package me_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int AD_W_DEF     = 8;
    localparam int BLK_PIX_DEF  = 64;
    localparam int NUM_CAND_DEF = 16;

    // A block sum of BLK_PIX values of AD_W bits needs log2(BLK_PIX) extra bits.
    function automatic int sad_w(input int ad_w, input int blk_pix);
        return ad_w + $clog2(blk_pix);
    endfunction

endpackage

// File: rtl/sad_accum_min_if.sv
// Pixel-in / result-out bundle for sad_accum_min; the candidate SAD monitor
// port pair exists only when ME_CAND_SAD_OUT_EN is defined.
// Slave side is the accumulator, master side is the pe array plus consumer.
interface sad_accum_min_if #(
    parameter int AD_W  = 8,
    parameter int SAD_W = 14,
    parameter int IDX_W = 4
) ();
    logic [AD_W-1:0]  ad_i;
    logic             ad_valid_i;
    logic             ad_ready_o;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [SAD_W-1:0] best_sad_o;
    logic [IDX_W-1:0] best_idx_o;
`ifdef ME_CAND_SAD_OUT_EN
    logic             cand_valid_o;
    logic [SAD_W-1:0] cand_sad_o;
`endif

    modport slave (
        input  ad_i, ad_valid_i, res_ready_i,
`ifdef ME_CAND_SAD_OUT_EN
        output cand_valid_o, cand_sad_o,
`endif
        output ad_ready_o, res_valid_o, best_sad_o, best_idx_o
    );

    modport master (
        output ad_i, ad_valid_i, res_ready_i,
`ifdef ME_CAND_SAD_OUT_EN
        input  cand_valid_o, cand_sad_o,
`endif
        input  ad_ready_o, res_valid_o, best_sad_o, best_idx_o
    );
endinterface

// File: rtl/sad_acc.sv
// Running block SAD plus pixel counter; flags the block's final pixel.
// Latency: sum_o is combinational (running sum + current ad_i), state updates next edge.
// Backpressure: none of its own; acc_en_i is the upstream accept strobe.
module sad_acc #(
    parameter int AD_W    = 8,
    parameter int BLK_PIX = 64,
    parameter int SAD_W   = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_en_i,
    input  logic [AD_W-1:0]  ad_i,
    output logic [SAD_W-1:0] sum_o,
    output logic             last_o
);
    localparam int PIX_W = $clog2(BLK_PIX);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(BLK_PIX - 1);

    logic [SAD_W-1:0] sum_q, sum_d;
    logic [PIX_W-1:0] cnt_q, cnt_d;

    assign sum_o  = sum_q + SAD_W'(ad_i);
    assign last_o = (cnt_q == LAST_PIX);

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (acc_en_i) begin
            if (last_o) begin
                sum_d = '0;
                cnt_d = '0;
            end else begin
                sum_d = sum_o;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sad_accum_min.sv
// Accumulates per-candidate SADs and keeps the minimum (lowest index on ties); optional ME_CAND_SAD_OUT_EN.
// Latency: result valid 1 cycle after the last pixel of the last candidate.
// Backpressure: ad_ready_o drops while a result waits for res_ready_i; pixels are not accepted then.
module sad_accum_min
    import me_pkg::*;
#(
    parameter int AD_W     = AD_W_DEF,
    parameter int BLK_PIX  = BLK_PIX_DEF,
    parameter int NUM_CAND = NUM_CAND_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    sad_accum_min_if.slave  bus
);
    localparam int SAD_W = sad_w(AD_W, BLK_PIX);
    localparam int IDX_W = $clog2(NUM_CAND);
    localparam logic [IDX_W-1:0] LAST_CAND = IDX_W'(NUM_CAND - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cand_q, cand_d;
    logic [SAD_W-1:0] best_sad_q, best_sad_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;

    logic             accept;
    logic             pix_last;
    logic             cand_done;
    logic             res_hs;
    logic [SAD_W-1:0] blk_sad;

    assign accept    = bus.ad_valid_i && (state_q == ACC);
    assign cand_done = accept && pix_last;
    assign res_hs    = (state_q == HOLD) && bus.res_ready_i;

    sad_acc #(
        .AD_W    (AD_W),
        .BLK_PIX (BLK_PIX),
        .SAD_W   (SAD_W)
    ) u_sad_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .acc_en_i (accept),
        .ad_i     (bus.ad_i),
        .sum_o    (blk_sad),
        .last_o   (pix_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:  if (cand_done && (cand_q == LAST_CAND)) state_d = HOLD;
            HOLD: if (res_hs) state_d = ACC;
        endcase
    end

    always_comb begin
        bus.ad_ready_o  = (state_q == ACC);
        bus.res_valid_o = (state_q == HOLD);
        bus.best_sad_o  = best_sad_q;
        bus.best_idx_o  = best_idx_q;
    end

    // Candidate counter parks on the last index until the result is taken.
    always_comb begin
        cand_d     = cand_q;
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
        if (res_hs) begin
            cand_d = '0;
        end else if (cand_done && (cand_q != LAST_CAND)) begin
            cand_d = cand_q + 1'b1;
        end
        if (cand_done && ((cand_q == '0) || (blk_sad < best_sad_q))) begin
            best_sad_d = blk_sad;
            best_idx_d = cand_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q     <= '0;
            best_sad_q <= '0;
            best_idx_q <= '0;
        end else begin
            cand_q     <= cand_d;
            best_sad_q <= best_sad_d;
            best_idx_q <= best_idx_d;
        end
    end

`ifdef ME_CAND_SAD_OUT_EN
    logic             cand_vld_q, cand_vld_d;
    logic [SAD_W-1:0] cand_sad_q, cand_sad_d;

    always_comb begin
        cand_vld_d = cand_done;
        cand_sad_d = cand_done ? blk_sad : cand_sad_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_vld_q <= 1'b0;
            cand_sad_q <= '0;
        end else begin
            cand_vld_q <= cand_vld_d;
            cand_sad_q <= cand_sad_d;
        end
    end

    assign bus.cand_valid_o = cand_vld_q;
    assign bus.cand_sad_o   = cand_sad_q;
`endif
endmodule
